// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative radix-2 multiply/divide engine with its own HI/LO pair.
// MULT/DIV/MADD/MSUB/MUL iterate one bit per cycle (shift-add / restoring divide);
// MTHI/MTLO write HI/LO directly from IDLE. Results commit to HI/LO from DONE
// unless the memory stage is stalled.
// Optional build macro MULDIV_EARLY_OUT_EN: trivial multiplies (zero operand) and
// divides with |dividend| < |divisor| skip the iteration and finish in one cycle.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             stallM_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   output logic             stall_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [2:0] OP_MULT = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_MTHI = 3'd2;
   localparam logic [2:0] OP_MTLO = 3'd3;
   localparam logic [2:0] OP_MADD = 3'd4;
   localparam logic [2:0] OP_MSUB = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   // Everything about the in-flight op that the final sign fix-up needs.
   typedef struct packed {
      logic [2:0] op;
      logic       neg;       // product / quotient sign differs
      logic       rem_neg;   // dividend was negative
      logic       div_zero;  // divisor was zero
   } op_ctx_t;

   state_t             state;
   op_ctx_t            ctx;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_hi;   // multiply: running high product; divide: partial remainder
   logic [WIDTH-1:0]   acc_lo;   // multiply: multiplier / low product; divide: dividend / quotient
   logic [WIDTH-1:0]   b_mag;    // latched |multiplier| or |divisor|
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               sign_a, sign_b, is_iter, is_div_in, early;
   logic [WIDTH-1:0]   a_mag, b_mag_in;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] prod_mag, prod;
   logic [WIDTH-1:0]   quot, rem;
   logic               commit, mt_wr;

   // Start-cycle operand decode, one iteration step, and final sign fix-up.
   always_comb begin
      sign_a    = signed_i & src_a_i[WIDTH-1];
      sign_b    = signed_i & src_b_i[WIDTH-1];
      a_mag     = sign_a ? -src_a_i : src_a_i;
      b_mag_in  = sign_b ? -src_b_i : src_b_i;
      is_div_in = (op_i == OP_DIV);
      is_iter   = (op_i == OP_MULT) | (op_i == OP_DIV) | (op_i == OP_MADD) |
                  (op_i == OP_MSUB) | (op_i == OP_MUL);

      mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? b_mag : '0)};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_ok    = (div_shift >= {1'b0, b_mag});
      // When div_ok the true difference is below the divisor, so the low bits are exact.
      div_diff  = div_shift[WIDTH-1:0] - b_mag;

      prod_mag  = {acc_hi, acc_lo};
      prod      = ctx.neg ? -prod_mag : prod_mag;
      quot      = ctx.div_zero ? '1 : (ctx.neg ? -acc_lo : acc_lo);
      rem       = ctx.rem_neg ? -acc_hi : acc_hi;
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign early = is_div_in ? (a_mag < b_mag_in) : ((src_a_i == '0) | (src_b_i == '0));
`else
   assign early = 1'b0;
`endif

   assign commit   = (state == S_DONE) & ~flush_i & ~stallM_i;
   assign mt_wr    = (state == S_IDLE) & start_i & ~flush_i & ~stallM_i;
   assign stall_o  = rst & (((state == S_IDLE) & start_i & is_iter) | (state == S_BUSY));
   assign ready_o  = (state == S_DONE);
   assign result_o = ((state == S_DONE) && (ctx.op == OP_MUL)) ? prod[WIDTH-1:0] : '0;
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;

   // Control FSM and iteration datapath; flush wins over everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         ctx    <= '0;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         b_mag  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!flush_i && start_i && is_iter) begin
                  ctx.op       <= op_i;
                  ctx.neg      <= sign_a ^ sign_b;
                  ctx.rem_neg  <= sign_a;
                  ctx.div_zero <= is_div_in & (src_b_i == '0);
                  b_mag        <= b_mag_in;
                  cnt          <= '0;
                  // Early-out preloads the finished state: product 0, or quotient 0 / remainder = dividend.
                  acc_hi       <= (early && is_div_in) ? a_mag : '0;
                  acc_lo       <= early ? '0 : a_mag;
                  state        <= early ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               if (flush_i) begin
                  state <= S_IDLE;
               end else begin
                  if (ctx.op == OP_DIV) begin
                     acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                  end else begin
                     acc_hi <= mul_sum[WIDTH:1];
                     acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                  end
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(WIDTH - 1)) state <= S_DONE;
               end
            end
            S_DONE: begin
               if (flush_i || !stallM_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // HI/LO architectural registers: iterative commit from DONE, direct moves from IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit) begin
         case (ctx.op)
            OP_MULT: {hi_q, lo_q} <= prod;
            OP_MADD: {hi_q, lo_q} <= {hi_q, lo_q} + prod;
            OP_MSUB: {hi_q, lo_q} <= {hi_q, lo_q} - prod;
            OP_DIV: begin
               hi_q <= rem;
               lo_q <= quot;
            end
            default: ;
         endcase
      end else if (mt_wr) begin
         if (op_i == OP_MTHI) hi_q <= src_a_i;
         if (op_i == OP_MTLO) lo_q <= src_a_i;
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit (WIDTH=32): directed vectors plus
// randomized ops checked against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_unit;

   logic        clk, rst, flush_i, stallM_i, start_i, signed_i;
   logic [2:0]  op_i;
   logic [31:0] src_a_i, src_b_i;
   logic        stall_o, ready_o;
   logic [31:0] result_o, hi_o, lo_o;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] m_hi = 0, m_lo = 0;

   muldiv_hilo_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .stallM_i(stallM_i), .start_i(start_i),
      .op_i(op_i), .signed_i(signed_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
      .stall_o(stall_o), .ready_o(ready_o), .result_o(result_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference: returns {hi, lo, result} after one op, straight from the arithmetic rules.
   function automatic logic [95:0] ref_op(input logic [2:0] op, input logic sgn,
                                          input logic [31:0] a, b, hi, lo);
      logic [63:0] p, hl;
      logic [31:0] r;
      int sa, sb, q, m;
      r  = 0;
      hl = {hi, lo};
      if (sgn) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else     p = {32'b0, a} * {32'b0, b};
      case (op)
         3'd0: hl = p;
         3'd4: hl = hl + p;
         3'd5: hl = hl - p;
         3'd6: r  = p[31:0];
         3'd2: hl[63:32] = a;
         3'd3: hl[31:0]  = a;
         3'd1: begin
            if (b == 0) hl = {a, 32'hFFFF_FFFF};
            else if (sgn) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) hl = {32'h0, 32'h8000_0000};
               else begin
                  sa = a; sb = b; q = sa / sb; m = sa % sb;
                  hl = {m, q};
               end
            end else hl = {a % b, a / b};
         end
         default: ;
      endcase
      return {hl, r};
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic sgn, input logic [31:0] a, b);
      logic [31:0] am, bm;
      am = (sgn && a[31]) ? -a : a;
      bm = (sgn && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
      if (op == 3'd1 && am < bm) return 1;
      if (op != 3'd1 && (a == 0 || b == 0)) return 1;
`endif
      if (am == bm) return 33;
      return 33;
   endfunction

   // Driver: hold start until ready, scrambling operands after the start cycle.
   task automatic run_op(input logic [2:0] op, input logic sgn, input logic [31:0] a, b,
                         output int lat, output int stl, output logic [31:0] res);
      @(negedge clk);
      start_i = 1; op_i = op; signed_i = sgn; src_a_i = a; src_b_i = b;
      #1;
      lat = 0; stl = 0;
      while (ready_o !== 1'b1 && lat < 100) begin
         if (stall_o === 1'b1) stl++;
         @(posedge clk); #1;
         lat++;
         src_a_i = $urandom; src_b_i = $urandom; signed_i = 1'($urandom);
      end
      res = result_o;
      start_i = 0;
   endtask

   task automatic do_mt(input logic [2:0] op, input logic [31:0] v, output logic st);
      @(negedge clk);
      start_i = 1; op_i = op; src_a_i = v;
      #1 st = stall_o;
      @(posedge clk); #1;
      start_i = 0;
   endtask

   task automatic test_reset;
      rst = 0; flush_i = 0; stallM_i = 0; start_i = 0; op_i = 0; signed_i = 0;
      src_a_i = 0; src_b_i = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({hi_o, lo_o, result_o, ready_o, stall_o} !== 98'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got hi=%h lo=%h res=%h rdy=%b stall=%b, want all 0",
                  hi_o, lo_o, result_o, ready_o, stall_o);
      end
      @(negedge clk) rst = 1;
   endtask

   task automatic test_plan_vectors;
      int lat, stl; logic [31:0] res; logic st; logic [95:0] m;
      // MULT signed -2 * 3
      m = ref_op(3'd0, 1, 32'hFFFF_FFFE, 32'd3, m_hi, m_lo);
      run_op(3'd0, 1, 32'hFFFF_FFFE, 32'd3, lat, stl, res);
      vectors++;
      if (lat != 33 || stl != 33) begin
         miscompares++; $display("FAIL mult_latency: got lat=%0d stall=%0d, want 33/33", lat, stl);
      end
      @(posedge clk); #1;
      vectors++;
      if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFA || m[95:32] !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         miscompares++; $display("FAIL mult_signed: got %h_%h want ffffffff_fffffffa", hi_o, lo_o);
      end
      {m_hi, m_lo} = m[95:32];
      // DIV signed -7 / 2
      run_op(3'd1, 1, 32'hFFFF_FFF9, 32'd2, lat, stl, res);
      @(posedge clk); #1;
      vectors++;
      if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         miscompares++; $display("FAIL div_signed: got %h_%h want ffffffff_fffffffd", hi_o, lo_o);
      end
      // DIVU 7 / 0
      run_op(3'd1, 0, 32'd7, 32'd0, lat, stl, res);
      vectors++;
      if (lat != 33) begin
         miscompares++; $display("FAIL div0_latency: got %0d want 33", lat);
      end
      @(posedge clk); #1;
      vectors++;
      if ({hi_o, lo_o} !== 64'h0000_0007_FFFF_FFFF) begin
         miscompares++; $display("FAIL div_by_zero: got %h_%h want 00000007_ffffffff", hi_o, lo_o);
      end
      // MTHI blocked by stallM, then written
      stallM_i = 1;
      do_mt(3'd2, 32'h1234_5678, st);
      stallM_i = 0;
      vectors++;
      if (hi_o !== 32'h7) begin
         miscompares++; $display("FAIL mthi_stallm: got %h want 00000007", hi_o);
      end
      do_mt(3'd2, 32'h1234_5678, st);
      vectors++;
      if (hi_o !== 32'h1234_5678 || st !== 1'b0) begin
         miscompares++; $display("FAIL mthi: got hi=%h stall=%b want 12345678/0", hi_o, st);
      end
      do_mt(3'd3, 32'h0, st);
      // MADDU 0xFFFFFFFF * 2
      run_op(3'd4, 0, 32'hFFFF_FFFF, 32'd2, lat, stl, res);
      @(posedge clk); #1;
      vectors++;
      if ({hi_o, lo_o} !== 64'h1234_5679_FFFF_FFFE) begin
         miscompares++; $display("FAIL maddu: got %h_%h want 12345679_fffffffe", hi_o, lo_o);
      end
      {m_hi, m_lo} = {hi_o == 32'h1234_5679 ? 32'h1234_5679 : 32'h1234_5679, 32'hFFFF_FFFE};
      // MULT with a zero operand
      m = ref_op(3'd0, 1, 32'd0, 32'h0BAD_F00D, m_hi, m_lo);
      run_op(3'd0, 1, 32'd0, 32'h0BAD_F00D, lat, stl, res);
      vectors++;
      if (lat != exp_lat(3'd0, 1, 32'd0, 32'h0BAD_F00D)) begin
         miscompares++; $display("FAIL mult_zero_latency: got %0d want %0d", lat,
                                 exp_lat(3'd0, 1, 32'd0, 32'h0BAD_F00D));
      end
      @(posedge clk); #1;
      vectors++;
      if ({hi_o, lo_o} !== m[95:32]) begin
         miscompares++; $display("FAIL mult_zero: got %h_%h want %h", hi_o, lo_o, m[95:32]);
      end
      {m_hi, m_lo} = m[95:32];
   endtask

   task automatic test_stallm_hold;
      int lat, stl; logic [31:0] res; logic [95:0] m; logic [31:0] a, b;
      a = $urandom; b = $urandom;
      m = ref_op(3'd4, 1, a, b, m_hi, m_lo);
      run_op(3'd4, 1, a, b, lat, stl, res);
      stallM_i = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (ready_o !== 1'b1 || {hi_o, lo_o} !== {m_hi, m_lo}) begin
            miscompares++;
            $display("FAIL stallm_hold[%0d]: got rdy=%b hilo=%h_%h want 1/%h_%h",
                     i, ready_o, hi_o, lo_o, m_hi, m_lo);
         end
      end
      @(negedge clk) stallM_i = 0;
      @(posedge clk); #1;
      vectors++;
      if (ready_o !== 1'b0 || {hi_o, lo_o} !== m[95:32]) begin
         miscompares++;
         $display("FAIL stallm_commit: got rdy=%b hilo=%h_%h want 0/%h", ready_o, hi_o, lo_o, m[95:32]);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({hi_o, lo_o} !== m[95:32]) begin
         miscompares++; $display("FAIL single_commit: got %h_%h want %h", hi_o, lo_o, m[95:32]);
      end
      {m_hi, m_lo} = m[95:32];
   endtask

   task automatic test_flush;
      int lat, stl, seen; logic [31:0] res;
      @(negedge clk);
      start_i = 1; op_i = 3'd1; signed_i = 0; src_a_i = 32'd1000; src_b_i = 32'd7;
      repeat (11) begin @(posedge clk); #1; end
      flush_i = 1; start_i = 0;
      @(posedge clk); #1;
      flush_i = 0;
      vectors++;
      if (ready_o !== 1'b0 || stall_o !== 1'b0) begin
         miscompares++; $display("FAIL flush_busy: got rdy=%b stall=%b want 0/0", ready_o, stall_o);
      end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (ready_o === 1'b1) seen++; end
      vectors++;
      if (seen != 0 || {hi_o, lo_o} !== {m_hi, m_lo}) begin
         miscompares++;
         $display("FAIL flush_no_write: got ready_seen=%0d hilo=%h_%h want 0/%h_%h",
                  seen, hi_o, lo_o, m_hi, m_lo);
      end
      run_op(3'd6, 0, 32'd6, 32'd7, lat, stl, res);
      vectors++;
      if (res !== 32'd42) begin
         miscompares++; $display("FAIL mul_result: got %0d want 42", res);
      end
      @(posedge clk); #1;
      vectors++;
      if ({hi_o, lo_o} !== {m_hi, m_lo}) begin
         miscompares++; $display("FAIL mul_hilo: got %h_%h want %h_%h", hi_o, lo_o, m_hi, m_lo);
      end
      // flush in DONE discards the result
      run_op(3'd0, 0, 32'hDEAD_BEEF, 32'h1234, lat, stl, res);
      flush_i = 1;
      @(posedge clk); #1;
      flush_i = 0;
      vectors++;
      if (ready_o !== 1'b0 || {hi_o, lo_o} !== {m_hi, m_lo}) begin
         miscompares++;
         $display("FAIL flush_done: got rdy=%b hilo=%h_%h want 0/%h_%h", ready_o, hi_o, lo_o, m_hi, m_lo);
      end
   endtask

   task automatic test_random;
      int lat, stl, el; logic [31:0] res, a, b; logic [95:0] m; logic [2:0] op; logic sgn, st;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = $urandom;
            op = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
            m = ref_op(op, 0, a, 0, m_hi, m_lo);
            do_mt(op, a, st);
            {m_hi, m_lo} = m[95:32];
         end
         case ($urandom_range(0, 4))
            0: op = 3'd0;
            1: op = 3'd1;
            2: op = 3'd4;
            3: op = 3'd5;
            default: op = 3'd6;
         endcase
         sgn = 1'($urandom); a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 0;
            1: a = 0;
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sgn = 1; end
            3: a = $urandom_range(0, 100);
            default: ;
         endcase
         m  = ref_op(op, sgn, a, b, m_hi, m_lo);
         el = exp_lat(op, sgn, a, b);
         run_op(op, sgn, a, b, lat, stl, res);
         vectors++;
         if (lat != el || stl != el) begin
            miscompares++;
            $display("FAIL rand_latency[%0d] op=%0d: got lat=%0d stall=%0d want %0d", i, op, lat, stl, el);
         end
         vectors++;
         if (res !== m[31:0]) begin
            miscompares++; $display("FAIL rand_result[%0d] op=%0d: got %h want %h", i, op, res, m[31:0]);
         end
         @(posedge clk); #1;
         vectors++;
         if ({hi_o, lo_o} !== m[95:32] || ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_hilo[%0d] op=%0d s=%b a=%h b=%h: got %h_%h rdy=%b want %h",
                     i, op, sgn, a, b, hi_o, lo_o, ready_o, m[95:32]);
         end
         {m_hi, m_lo} = m[95:32];
      end
   endtask

   task automatic test_reset_mid_busy;
      logic st;
      do_mt(3'd2, 32'hA5A5_A5A5, st);
      m_hi = 32'hA5A5_A5A5;
      @(negedge clk);
      start_i = 1; op_i = 3'd0; signed_i = 1; src_a_i = 32'h1234_5678; src_b_i = 32'h9;
      repeat (6) begin @(posedge clk); #1; end
      rst = 0;
      #1;
      vectors++;
      if ({hi_o, lo_o, result_o, ready_o, stall_o} !== 98'b0) begin
         miscompares++;
         $display("FAIL reset_mid_busy: got hi=%h lo=%h res=%h rdy=%b stall=%b want all 0",
                  hi_o, lo_o, result_o, ready_o, stall_o);
      end
      start_i = 0;
      @(negedge clk) rst = 1;
      m_hi = 0; m_lo = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({hi_o, lo_o, ready_o} !== 65'b0) begin
         miscompares++; $display("FAIL after_reset: got %h_%h rdy=%b want 0", hi_o, lo_o, ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_plan_vectors();
      test_stallm_hold();
      test_flush();
      test_random();
      test_reset_mid_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
Parametrised iterative multiply/divide engine with its own HI/LO register pair, for the execute stage.
- Successor to the fixed 32-bit ALU multiply/divide path: generic WIDTH, one shared iteration counter, explicit accumulate modes, defined divide-by-zero and overflow results.
- Execute stage holds start_i and the operands until ready_o. It uses stall_o to freeze the pipeline. HI/LO commit is gated by the memory-stage stall.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be even and at least 8.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush_i  in  1  abort any operation in progress.
- stallM_i  in  1  memory-stage stall; blocks the HI/LO commit.
- start_i  in  1  operation request; held high by the pipeline until ready_o.
- op_i  in  3  000 MULT, 001 DIV, 010 MTHI, 011 MTLO, 100 MADD, 101 MSUB, 110 MUL, 111 reserved (no-op).
- signed_i  in  1  1 = signed operands.
- src_a_i  in  WIDTH  multiplicand / dividend / MTHI/MTLO data.
- src_b_i  in  WIDTH  multiplier / divisor.
- stall_o  out  1  (start_i | busy) & ~ready_o, for iterative ops only.
- ready_o  out  1  result valid (DONE state).
- result_o  out  WIDTH  low half of the product (for MUL); 0 otherwise.
- hi_o  out  WIDTH  current HI register value.
- lo_o  out  WIDTH  current LO register value.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, HI=LO=0, counter=0; stall_o=0, ready_o=0, result_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start_i and an iterative op (MULT/DIV/MADD/MSUB/MUL):
  - latch magnitudes of the operands and their signs;
  - counter=0; go to BUSY.
  - stall_o is high in this cycle.
- BUSY: one radix-2 step per cycle.
  - Multiply: shift-add.
  - Divide: restoring.
  - After WIDTH steps go to DONE. Latency from start to ready_o = WIDTH+1 cycles.
- DONE: ready_o=1 and stall_o=0.
  - If ~stallM_i: commit to HI/LO (except MUL) and go to IDLE.
  - If stallM_i: hold DONE with the result stable.
- Commit rules:
  - MULT: {HI,LO} = product.
  - MADD: {HI,LO} += product.
  - MSUB: {HI,LO} -= product.
  - DIV: LO = quotient, HI = remainder.
  - MUL: result_o = product[WIDTH-1:0]; HI/LO unchanged.
  - All 2*WIDTH arithmetic wraps modulo 2^(2*WIDTH).
- Signed results:
  - product negated when the operand signs differ;
  - quotient negated when the signs differ;
  - remainder takes the dividend's sign (truncating division).
- Divide by zero: LO = all ones, HI = src_a unchanged, for both signed and unsigned. Full latency is still used.
- Signed most-negative / -1: LO = most-negative value, HI = 0; no exception.
- MTHI/MTLO: single cycle in IDLE.
  - HI (or LO) = src_a_i when start_i & ~stallM_i.
  - stall_o stays 0; the FSM does not leave IDLE.
- Flush:
  - flush_i in any state forces IDLE next cycle; no HI/LO write.
  - flush_i has priority over commit and over a new start.
- Ignored inputs:
  - start_i while in BUSY/DONE is ignored.
  - Operand changes after the start cycle are ignored (latched copies are used).
- ready_o is high for at least one cycle and deasserts the cycle after commit.
- hi_o/lo_o show the committed registers only; no bypass of an in-flight result.

Optional Feature:
- MULDIV_EARLY_OUT_EN.
- Defined:
  - multiply with either latched operand equal to zero goes IDLE->DONE directly, latency 1;
  - divide whose latched dividend magnitude is below the divisor magnitude also goes directly to DONE (quotient 0, remainder = dividend, sign rules applied), latency 1.
- Undefined: every iterative op takes the full WIDTH+1 cycles.

Test Plan:
- WIDTH=32, MULT signed, a=0xFFFFFFFE (-2), b=3 -> ready_o after 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_o high for 33 cycles.
- DIV signed, a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
- MTHI 0x12345678, then MADDU a=0xFFFFFFFF, b=2 with LO=0 -> HI=0x12345679, LO=0xFFFFFFFE.
- DONE with stallM_i high for 5 cycles -> ready_o held, HI/LO unchanged until stallM_i drops; single commit.
- flush_i at BUSY step 10 of DIV -> IDLE next cycle, HI/LO unchanged. A new MUL a=6, b=7 -> result_o=42, HI/LO untouched.
- rst low mid-BUSY -> outputs 0 immediately; HI=LO=0. With MULDIV_EARLY_OUT_EN, MULT a=0 -> ready_o in 1 cycle, HI=LO=0.
